multicycle_ctrl: RTL and testbench

- Multicycle RV32I control FSM; the initiator side of the ALU command interface.
- Decodes the instruction register and sequences fetch/decode/execute/memory/writeback.
- Drives the 4-bit ALU opcode, operand selects and datapath strobes; consumes the ALU `zero` flag for branch resolution.
- Sits between instruction register, register file, memory port and ALU in the core datapath.

---
 rtl/multicycle_ctrl.sv | 237 +++++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multicycle RV32I control FSM driving the ALU command interface
// Optional retired-instruction counter output enabled by defining CTRL_INSTRET_EN.
module multicycle_ctrl #(
  parameter int RESET_STATE_FETCH = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  input  logic        zero,
  input  logic        mem_ready,
  output logic [3:0]  ALU_ctr,
  output logic [1:0]  alu_srcA_sel,
  output logic [1:0]  alu_srcB_sel,
  output logic [2:0]  imm_sel,
  output logic        pc_write,
  output logic        pc_src,
  output logic        ir_write,
  output logic        mem_req,
  output logic        mem_we,
  output logic        adr_src,
  output logic        reg_write,
  output logic [1:0]  result_src,
  output logic        illegal
`ifdef CTRL_INSTRET_EN
  ,
  output logic [31:0] instret
`endif
);

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_ALU_WB, S_MEM_ADDR,
    S_MEM_RD, S_MEM_WB, S_MEM_WR, S_BRANCH, S_JAL, S_TRAP
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;

  if (RESET_STATE_FETCH != 1) begin : g_param_check
    $error("RESET_STATE_FETCH must be 1");
  end

  state_t     r_state;
  state_t     w_next;
  logic [6:0] w_opcode;
  logic [2:0] w_funct3;
  logic [6:0] w_funct7;
  logic       w_funct7_ok;
  logic [3:0] w_arith_ctr;
  logic       w_arith_ok;
  logic [3:0] w_br_ctr;
  logic       w_br_ok;
  logic       w_unused;

  assign w_opcode    = instr[6:0];
  assign w_funct3    = instr[14:12];
  assign w_funct7    = instr[31:25];
  assign w_funct7_ok = (w_funct7 == 7'b0000000) || (w_funct7 == 7'b0100000);
  assign w_unused    = &{1'b0, instr[24:15], instr[11:7]};

  // Shared funct3 decode for R-type/I-type arithmetic and for branch compares.
  always_comb begin
    w_arith_ok  = 1'b1;
    w_arith_ctr = ALU_ADD;
    case (w_funct3)
      3'b000:  w_arith_ctr = ALU_ADD;
      3'b001:  w_arith_ctr = 4'b0101;
      3'b010:  w_arith_ctr = 4'b0111;
      3'b100:  w_arith_ctr = 4'b0100;
      3'b101:  w_arith_ctr = 4'b0110;
      3'b110:  w_arith_ctr = 4'b0011;
      3'b111:  w_arith_ctr = 4'b0010;
      default: w_arith_ok  = 1'b0;
    endcase
    w_br_ok  = 1'b1;
    w_br_ctr = 4'b1000;
    case (w_funct3)
      3'b000:  w_br_ctr = 4'b1000;
      3'b001:  w_br_ctr = 4'b1001;
      3'b100:  w_br_ctr = 4'b1010;
      3'b101:  w_br_ctr = 4'b1011;
      3'b110:  w_br_ctr = 4'b1100;
      3'b111:  w_br_ctr = 4'b1101;
      default: w_br_ok  = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_FETCH;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next       = r_state;
    ALU_ctr      = ALU_ADD;
    alu_srcA_sel = 2'b00;
    alu_srcB_sel = 2'b00;
    imm_sel      = 3'b000;
    pc_write     = 1'b0;
    pc_src       = 1'b0;
    ir_write     = 1'b0;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    adr_src      = 1'b0;
    reg_write    = 1'b0;
    result_src   = 2'b00;
    illegal      = 1'b0;
    case (r_state)
      S_FETCH: begin
        mem_req      = 1'b1;
        alu_srcB_sel = 2'b10;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          w_next   = S_DECODE;
        end
      end
      S_DECODE: begin
        // Branch/jump target is precomputed here into ALUout.
        alu_srcA_sel = 2'b01;
        alu_srcB_sel = 2'b01;
        if (w_opcode == OP_BRANCH)   imm_sel = 3'b010;
        else if (w_opcode == OP_JAL) imm_sel = 3'b011;
        case (w_opcode)
          OP_R:              w_next = S_EXEC_R;
          OP_IMM, OP_LUI:    w_next = S_EXEC_I;
          OP_LOAD, OP_STORE: w_next = S_MEM_ADDR;
          OP_BRANCH:         w_next = S_BRANCH;
          OP_JAL:            w_next = S_JAL;
          default:           w_next = S_TRAP;
        endcase
      end
      S_EXEC_R: begin
        alu_srcA_sel = 2'b10;
        alu_srcB_sel = 2'b00;
        ALU_ctr      = (w_funct3 == 3'b000 && w_funct7[5]) ? ALU_SUB : w_arith_ctr;
        w_next       = (w_arith_ok && w_funct7_ok) ? S_ALU_WB : S_TRAP;
      end
      S_EXEC_I: begin
        alu_srcB_sel = 2'b01;
        if (w_opcode == OP_IMM) begin
          alu_srcA_sel = 2'b10;
          ALU_ctr      = w_arith_ctr;
        end else begin
          alu_srcA_sel = 2'b11;
          imm_sel      = 3'b100;
        end
        w_next = S_ALU_WB;
      end
      S_ALU_WB: begin
        reg_write = 1'b1;
        w_next    = S_FETCH;
      end
      S_MEM_ADDR: begin
        alu_srcA_sel = 2'b10;
        alu_srcB_sel = 2'b01;
        imm_sel      = (w_opcode == OP_STORE) ? 3'b001 : 3'b000;
        w_next       = (w_opcode == OP_STORE) ? S_MEM_WR : S_MEM_RD;
      end
      S_MEM_RD: begin
        mem_req = 1'b1;
        adr_src = 1'b1;
        if (mem_ready) w_next = S_MEM_WB;
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        result_src = 2'b01;
        w_next     = S_FETCH;
      end
      S_MEM_WR: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        adr_src = 1'b1;
        if (mem_ready) w_next = S_FETCH;
      end
      S_BRANCH: begin
        alu_srcA_sel = 2'b10;
        alu_srcB_sel = 2'b00;
        ALU_ctr      = w_br_ctr;
        if (w_br_ok) begin
          pc_write = ~zero;
          pc_src   = 1'b1;
          w_next   = S_FETCH;
        end else begin
          w_next   = S_TRAP;
        end
      end
      S_JAL: begin
        reg_write  = 1'b1;
        result_src = 2'b11;
        pc_write   = 1'b1;
        pc_src     = 1'b1;
        w_next     = S_FETCH;
      end
      S_TRAP:  illegal = 1'b1;
      default: w_next  = S_FETCH;
    endcase
    // Reset quiesces the datapath in the same cycle so an aborted instruction writes nothing.
    if (rst) begin
      ALU_ctr      = ALU_ADD;
      alu_srcA_sel = 2'b00;
      alu_srcB_sel = 2'b00;
      imm_sel      = 3'b000;
      pc_write     = 1'b0;
      pc_src       = 1'b0;
      ir_write     = 1'b0;
      mem_req      = 1'b0;
      mem_we       = 1'b0;
      adr_src      = 1'b0;
      reg_write    = 1'b0;
      result_src   = 2'b00;
      illegal      = 1'b0;
    end
  end

`ifdef CTRL_INSTRET_EN
  logic [31:0] r_instret;
  logic        w_retire;

  assign w_retire = (w_next == S_FETCH) && (r_state != S_FETCH) && (r_state != S_TRAP);

  always_ff @(posedge clk) begin
    if (rst)           r_instret <= 32'd0;
    else if (w_retire) r_instret <= r_instret + 32'd1;
  end

  assign instret = r_instret;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - randomized self-checking bench for multicycle_ctrl
module tb_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr;
  logic        zero;
  logic        mem_ready;
  logic [3:0]  ALU_ctr;
  logic [1:0]  alu_srcA_sel;
  logic [1:0]  alu_srcB_sel;
  logic [2:0]  imm_sel;
  logic        pc_write;
  logic        pc_src;
  logic        ir_write;
  logic        mem_req;
  logic        mem_we;
  logic        adr_src;
  logic        reg_write;
  logic [1:0]  result_src;
  logic        illegal;
`ifdef CTRL_INSTRET_EN
  logic [31:0] instret;
`endif

  multicycle_ctrl dut (
    .clk(clk), .rst(rst), .instr(instr), .zero(zero), .mem_ready(mem_ready),
    .ALU_ctr(ALU_ctr), .alu_srcA_sel(alu_srcA_sel), .alu_srcB_sel(alu_srcB_sel),
    .imm_sel(imm_sel), .pc_write(pc_write), .pc_src(pc_src), .ir_write(ir_write),
    .mem_req(mem_req), .mem_we(mem_we), .adr_src(adr_src), .reg_write(reg_write),
    .result_src(result_src), .illegal(illegal)
`ifdef CTRL_INSTRET_EN
    , .instret(instret)
`endif
  );

  always #5 clk = ~clk;

  // Observed vector: ctr[20:17] srcA[16:15] srcB[14:13] imm[12:10] pcw[9] pcs[8]
  // irw[7] mreq[6] mwe[5] adr[4] rw[3] res[2:1] ill[0]
  logic [20:0] obs;
  assign obs = {ALU_ctr, alu_srcA_sel, alu_srcB_sel, imm_sel, pc_write, pc_src, ir_write,
                mem_req, mem_we, adr_src, reg_write, result_src, illegal};

  localparam logic [20:0] M_STB = 21'h0002E9;
  localparam logic [20:0] M_CTR = 21'h1E0000;
  localparam logic [20:0] M_SRC = 21'h01E000;
  localparam logic [20:0] M_IMM = 21'h001C00;
  localparam logic [20:0] M_PCS = 21'h000100;
  localparam logic [20:0] M_ADR = 21'h000010;
  localparam logic [20:0] M_RES = 21'h000006;

  typedef struct {
    string       name;
    logic [20:0] v;
    logic [20:0] m;
    logic        mr;
    logic        z;
  } rec_t;

  rec_t        q[$];
  int          n_checks = 0;
  int          n_errors = 0;
  int          retired  = 0;
  logic [3:0]  arith_tbl[8];
  logic [3:0]  br_tbl[8];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [20:0] pk(input logic [3:0] ctr, input logic [1:0] a,
      input logic [1:0] b, input logic [2:0] imm, input logic pcw, input logic pcs,
      input logic irw, input logic mr, input logic mwe, input logic adr, input logic rw,
      input logic [1:0] res, input logic ill);
    return {ctr, a, b, imm, pcw, pcs, irw, mr, mwe, adr, rw, res, ill};
  endfunction

  task automatic push(input string name, input logic [20:0] v, input logic [20:0] m,
                      input logic mr, input logic z);
    rec_t r;
    r.name = name; r.v = v; r.m = m | M_STB; r.mr = mr; r.z = z;
    q.push_back(r);
  endtask

  // Expected per-cycle behaviour of one instruction, built from the opcode rules.
  task automatic gen(input logic [31:0] ins, input int fw, input int mw, input logic z,
                     output bit trapped);
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    logic [2:0] dimm;
    logic [3:0] ctr;
    op = ins[6:0]; f3 = ins[14:12]; f7 = ins[31:25];
    trapped = 1'b0;
    for (int i = 0; i < fw; i++)
      push("fetch_wait", pk(0, 0, 2, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0), M_CTR | M_SRC | M_ADR, 1'b0, rb());
    push("fetch", pk(0, 0, 2, 0, 1, 0, 1, 1, 0, 0, 0, 0, 0), M_CTR | M_SRC | M_ADR | M_PCS, 1'b1, rb());
    dimm = (op == 7'b1100011) ? 3'b010 : 3'b011;
    push("decode", pk(0, 1, 1, dimm, 0, 0, 0, 0, 0, 0, 0, 0, 0),
         M_CTR | M_SRC | ((op == 7'b1100011 || op == 7'b1101111) ? M_IMM : 21'h0), rb(), rb());
    case (op)
      7'b0110011: begin
        if ((f7 == 7'h00 || f7 == 7'h20) && f3 != 3'b011) begin
          ctr = (f3 == 3'b000 && f7 == 7'h20) ? 4'b0001 : arith_tbl[f3];
          push("exec_r", pk(ctr, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), M_CTR | M_SRC, rb(), rb());
          push("alu_wb", pk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0), M_RES, rb(), rb());
        end else begin
          push("exec_r_bad", 21'h0, 21'h0, rb(), rb());
          trapped = 1'b1;
        end
      end
      7'b0010011: begin
        push("exec_i", pk(arith_tbl[f3], 2, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0),
             M_CTR | M_SRC | M_IMM, rb(), rb());
        push("alu_wb", pk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0), M_RES, rb(), rb());
      end
      7'b0110111: begin
        push("exec_lui", pk(0, 3, 1, 4, 0, 0, 0, 0, 0, 0, 0, 0, 0), M_CTR | M_SRC | M_IMM, rb(), rb());
        push("alu_wb", pk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0), M_RES, rb(), rb());
      end
      7'b0000011: begin
        push("mem_addr_ld", pk(0, 2, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), M_CTR | M_SRC | M_IMM, rb(), rb());
        for (int i = 0; i < mw; i++)
          push("mem_rd_wait", pk(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0), M_ADR, 1'b0, rb());
        push("mem_rd", pk(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0), M_ADR, 1'b1, rb());
        push("mem_wb", pk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0), M_RES, rb(), rb());
      end
      7'b0100011: begin
        push("mem_addr_st", pk(0, 2, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0), M_CTR | M_SRC | M_IMM, rb(), rb());
        for (int i = 0; i < mw; i++)
          push("mem_wr_wait", pk(0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0, 0), M_ADR, 1'b0, rb());
        push("mem_wr", pk(0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0, 0), M_ADR, 1'b1, rb());
      end
      7'b1100011: begin
        if (f3 == 3'b010 || f3 == 3'b011) begin
          push("branch_bad", 21'h0, 21'h0, rb(), z);
          trapped = 1'b1;
        end else begin
          push("branch", pk(br_tbl[f3], 2, 0, 0, ~z, 1, 0, 0, 0, 0, 0, 0, 0),
               M_CTR | M_SRC | M_PCS, rb(), z);
        end
      end
      7'b1101111:
        push("jal", pk(0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 1, 3, 0), M_PCS | M_RES, rb(), rb());
      default: trapped = 1'b1;
    endcase
    if (trapped) begin
      for (int i = 0; i < 3; i++)
        push("trap", pk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1), 21'h0, rb(), rb());
    end
  endtask

  // Entered and left at posedge+1: drive inputs, sample at negedge, advance one clock.
  task automatic run_q(input logic [31:0] ins);
    rec_t r;
    while (q.size() > 0) begin
      r = q.pop_front();
      instr = ins; mem_ready = r.mr; zero = r.z;
      @(negedge clk);
      check(r.name, 32'(obs & r.m), 32'(r.v & r.m));
      @(posedge clk); #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; mem_ready = rb(); zero = rb();
    @(posedge clk); #1;
    rst = 1'b0;
    retired = 0;
  endtask

  task automatic exec(input logic [31:0] ins, input int fw, input int mw, input logic z);
    bit trapped;
    gen(ins, fw, mw, z, trapped);
    run_q(ins);
    if (trapped) do_reset();
    else retired++;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    int k;
    w = $urandom;
    k = $urandom_range(0, 8);
    case (k)
      0, 1: begin
        w[6:0] = 7'b0110011;
        case ($urandom_range(0, 3))
          0, 1:    w[31:25] = 7'h00;
          2:       w[31:25] = 7'h20;
          default: ;
        endcase
      end
      2: begin
        w[6:0] = 7'b0010011;
        if (w[14:12] == 3'b011) w[14:12] = 3'b000;
      end
      3: w[6:0] = 7'b0110111;
      4: w[6:0] = 7'b0000011;
      5: w[6:0] = 7'b0100011;
      6: w[6:0] = 7'b1100011;
      7: w[6:0] = 7'b1101111;
      default: begin
        while (w[6:0] == 7'b0110011 || w[6:0] == 7'b0010011 || w[6:0] == 7'b0110111 ||
               w[6:0] == 7'b0000011 || w[6:0] == 7'b0100011 || w[6:0] == 7'b1100011 ||
               w[6:0] == 7'b1101111)
          w[6:0] = 7'($urandom);
      end
    endcase
    return w;
  endfunction

  initial begin
    arith_tbl[0] = 4'b0000; arith_tbl[1] = 4'b0101; arith_tbl[2] = 4'b0111; arith_tbl[3] = 4'b0000;
    arith_tbl[4] = 4'b0100; arith_tbl[5] = 4'b0110; arith_tbl[6] = 4'b0011; arith_tbl[7] = 4'b0010;
    br_tbl[0] = 4'b1000; br_tbl[1] = 4'b1001; br_tbl[2] = 4'b0000; br_tbl[3] = 4'b0000;
    br_tbl[4] = 4'b1010; br_tbl[5] = 4'b1011; br_tbl[6] = 4'b1100; br_tbl[7] = 4'b1101;

    rst = 1'b1; instr = 32'h0; zero = 1'b0; mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    exec(32'h002081B3, 0, 0, 1'b0);
    exec(32'h402081B3, 0, 0, 1'b0);
    exec(32'h0020A1B3, 1, 0, 1'b0);
    exec(32'h00208463, 0, 0, 1'b0);
    exec(32'h00208463, 0, 0, 1'b1);
    exec(32'h0040A283, 0, 3, 1'b0);
    exec(32'h0050A423, 2, 1, 1'b0);
    exec(32'h008000EF, 0, 0, 1'b0);
    exec(32'h123452B7, 0, 0, 1'b0);
    exec(32'h00508093, 0, 0, 1'b0);
    exec(32'hFFFFFFFF, 0, 0, 1'b0);

    for (int n = 0; n < 300; n++)
      exec(rand_instr(), $urandom_range(0, 2), $urandom_range(0, 3), rb());

`ifdef CTRL_INSTRET_EN
    @(negedge clk);
    check("instret", instret, 32'(retired));
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
